micro_sequencer: RTL and testbench

Micro-program sequencer for the microcoded CPU. It sits directly downstream of the flag unit: each cycle it consumes the jump bit `j_out` from the flag unit, combines it with the current microinstruction's next-address field, the optional MBR dispatch and a small micro-call stack, and holds the micro-program counter (MPC) that addresses the control store. It also generates the `set_f` strobe that tells the flag unit when to latch the ALU Z flag. Stalls on memory-busy are handled here.

---
 rtl/mic_pkg.sv | 24 ++
 rtl/micro_sequencer_if.sv | 36 +++
 rtl/micro_stack.sv | 44 ++++
 rtl/micro_sequencer.sv | 127 ++++++++++++
 tb/tb_micro_sequencer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mic_pkg.sv
// Shared types and defaults for the micro-program sequencer of the microcoded CPU.
// Holds the sequencer state encoding and the next-address select codes.
package mic_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int MBR_W_DEF  = 8;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } seq_state_t;

  // Source of the MPC on a commit edge; SEL_HOLD means no commit this cycle.
  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_NORMAL = 2'd1,
    SEL_CALL   = 2'd2,
    SEL_RET    = 2'd3
  } addr_sel_t;

endpackage

// File: rtl/micro_sequencer_if.sv
// Microinstruction-field and status bundle between the datapath/flag unit and the sequencer.
// master drives the microinstruction fields, slave is the sequencer.
interface micro_sequencer_if #(
  parameter int ADDR_W = mic_pkg::ADDR_W_DEF,
  parameter int MBR_W  = mic_pkg::MBR_W_DEF
);

  // Handshake: there is no valid/ready pair. The master holds the microinstruction
  // fields while the sequencer is in EXEC/WAIT; they are consumed only on the commit
  // cycle, i.e. the first EXEC/WAIT cycle with mem_busy low, flagged by set_f (or by
  // halted rising). Field values on any other cycle are ignored.
  logic [ADDR_W-1:0] next_addr;
  logic              j_out;
  logic              jmpc;
  logic [MBR_W-1:0]  mbr;
  logic              call;
  logic              ret;
  logic              halt;
  logic              mem_busy;
  logic [ADDR_W-1:0] mpc;
  logic              cs_rd;
  logic              set_f;
  logic              halted;
  logic              stk_err;

  modport master (
    output next_addr, j_out, jmpc, mbr, call, ret, halt, mem_busy,
    input  mpc, cs_rd, set_f, halted, stk_err
  );

  modport slave (
    input  next_addr, j_out, jmpc, mbr, call, ret, halt, mem_busy,
    output mpc, cs_rd, set_f, halted, stk_err
  );

endinterface

// File: rtl/micro_stack.sv
// Micro-call return-address stack (LIFO) with full/empty flags and a top-of-stack view.
// Push on full and pop on empty are ignored; the sequencer flags those as errors.
module micro_stack #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SP_W  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SP_W-1:0]  sp;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  // sp counts live entries, so the newest entry sits at sp-1.
  assign wr_idx  = IDX_W'(sp);
  assign top_idx = IDX_W'(sp - SP_W'(1));
  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  assign top     = mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= push_data;
      sp          <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-program sequencer: FETCH/EXEC/WAIT/HALT FSM, MPC register and micro-call stack.
// Produces the control-store read strobe and the set_f flag-latch strobe.
module micro_sequencer
  import mic_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MBR_W     = MBR_W_DEF,
  parameter int STK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  micro_sequencer_if.slave bus,
  output seq_state_t seq_state
);

  seq_state_t        state;
  seq_state_t        state_next;
  addr_sel_t         sel;
  logic              push;
  logic              pop;
  logic              err_set;
  logic              stk_full;
  logic              stk_empty;
  logic [ADDR_W-1:0] mpc;
  logic [ADDR_W-1:0] mpc_plus1;
  logic [ADDR_W-1:0] stk_top;
  logic [ADDR_W-1:0] normal_addr;
  logic              stk_err;

  assign mpc_plus1 = mpc + ADDR_W'(1);

  // Plain OR of the three sources: a jump or dispatch never carries into higher bits.
  assign normal_addr = bus.next_addr
                     | {bus.j_out, {(ADDR_W-1){1'b0}}}
                     | (bus.jmpc ? {{(ADDR_W-MBR_W){1'b0}}, bus.mbr} : '0);

  micro_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (mpc_plus1),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RESET;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    sel        = SEL_HOLD;
    push       = 1'b0;
    pop        = 1'b0;
    err_set    = 1'b0;
    case (state)
      S_RESET: state_next = S_FETCH;
      S_FETCH: state_next = S_EXEC;
      S_EXEC, S_WAIT: begin
        if (bus.mem_busy) begin
          state_next = S_WAIT;
        end else if (bus.halt) begin
          state_next = S_HALT;
        end else if (bus.ret) begin
          if (stk_empty) begin
            err_set    = 1'b1;
            state_next = S_HALT;
          end else begin
            pop        = 1'b1;
            sel        = SEL_RET;
            state_next = S_FETCH;
          end
        end else if (bus.call) begin
          if (stk_full) begin
            err_set    = 1'b1;
            state_next = S_HALT;
          end else begin
            push       = 1'b1;
            sel        = SEL_CALL;
            state_next = S_FETCH;
          end
        end else begin
          sel        = SEL_NORMAL;
          state_next = S_FETCH;
        end
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_RESET;
    endcase
  end

  // set_f marks exactly the commits that load a new MPC; halt and stack errors do not.
  always_comb begin
    bus.cs_rd  = (state == S_FETCH);
    bus.halted = (state == S_HALT);
    bus.set_f  = (sel != SEL_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mpc <= '0;
    end else begin
      case (sel)
        SEL_NORMAL: mpc <= normal_addr;
        SEL_CALL:   mpc <= bus.next_addr;
        SEL_RET:    mpc <= stk_top;
        default:    mpc <= mpc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          stk_err <= 1'b0;
    else if (err_set) stk_err <= 1'b1;
  end

  assign bus.mpc     = mpc;
  assign bus.stk_err = stk_err;
  assign seq_state   = state;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: transaction-level reference model,
// per-cycle compare process, commit scoreboard and directed literal checks.
module tb_micro_sequencer;
  import mic_pkg::*;

  localparam int AW    = 9;
  localparam int MW    = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  seq_state_t seq_state;

  micro_sequencer_if #(.ADDR_W(AW), .MBR_W(MW)) bus ();

  micro_sequencer #(
    .ADDR_W    (AW),
    .MBR_W     (MW),
    .STK_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .seq_state (seq_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_setf   = 0;
  int n_wait   = 0;

  // reference model state
  logic [AW-1:0] m_mpc    = '0;
  logic [AW-1:0] m_stk[$];
  logic          m_err    = 1'b0;
  logic          m_halted = 1'b0;

  // expected per-cycle outputs and the queue of committed MPC values
  logic [AW-1:0] exp_q[$];
  logic          pend        = 1'b0;
  logic [AW-1:0] exp_mpc     = '0;
  logic          exp_cs_rd   = 1'b0;
  logic          exp_set_f   = 1'b0;
  logic          exp_halted  = 1'b0;
  logic          exp_stk_err = 1'b0;

  task automatic check_a(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
    end
  endtask

  // compare process
  always @(negedge clk) begin
    check_a("mpc", bus.mpc, exp_mpc);
    check_b("cs_rd", bus.cs_rd, exp_cs_rd);
    check_b("set_f", bus.set_f, exp_set_f);
    check_b("halted", bus.halted, exp_halted);
    check_b("stk_err", bus.stk_err, exp_stk_err);
    if (pend) begin
      pend = 1'b0;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL commit_mpc: got 0x%0h after set_f, expected no commit (t=%0t)", bus.mpc, $time);
      end else begin
        check_a("commit_mpc", bus.mpc, exp_q.pop_front());
      end
    end
    if (bus.set_f === 1'b1) begin
      pend = 1'b1;
      n_setf++;
    end
    if (seq_state == S_WAIT) n_wait++;
  end

  task automatic noise();
    bus.next_addr = AW'($urandom);
    bus.j_out     = 1'($urandom);
    bus.jmpc      = 1'($urandom);
    bus.mbr       = MW'($urandom);
    bus.call      = 1'($urandom);
    bus.ret       = 1'($urandom);
    bus.halt      = 1'($urandom);
    bus.mem_busy  = 1'($urandom);
  endtask

  task automatic set_exp_fetch();
    exp_mpc = m_mpc; exp_cs_rd = 1'b1; exp_set_f = 1'b0;
    exp_halted = 1'b0; exp_stk_err = m_err;
  endtask

  task automatic set_exp_halt();
    exp_mpc = m_mpc; exp_cs_rd = 1'b0; exp_set_f = 1'b0;
    exp_halted = 1'b1; exp_stk_err = m_err;
  endtask

  task automatic set_exp_reset();
    exp_mpc = '0; exp_cs_rd = 1'b0; exp_set_f = 1'b0;
    exp_halted = 1'b0; exp_stk_err = 1'b0;
  endtask

  // Called at posedge+1 of any cycle; asserts rst mid-cycle, holds it, releases it
  // and returns at posedge+1 of the first FETCH.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    m_mpc = '0; m_stk.delete(); m_err = 1'b0; m_halted = 1'b0;
    exp_q.delete(); pend = 1'b0;
    set_exp_reset();
    #1;
    check_a("rst_mpc", bus.mpc, 9'h000);
    check_b("rst_cs_rd", bus.cs_rd, 1'b0);
    check_b("rst_set_f", bus.set_f, 1'b0);
    check_b("rst_halted", bus.halted, 1'b0);
    check_b("rst_stk_err", bus.stk_err, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    set_exp_fetch();
    check_a("first_fetch_mpc", bus.mpc, 9'h000);
    check_b("first_fetch_cs_rd", bus.cs_rd, 1'b1);
  endtask

  // Entered at posedge+1 of a FETCH cycle; returns at posedge+1 after the commit edge.
  task automatic run_instr(input logic [AW-1:0] na, input logic j, input logic jm,
                           input logic [MW-1:0] mb, input logic c, input logic r,
                           input logic h, input int busy);
    logic          upd;
    logic          to_halt;
    logic          err;
    logic          do_push;
    logic          do_pop;
    logic [AW-1:0] nxt;
    noise();
    set_exp_fetch();
    @(posedge clk); #1;
    for (int i = 0; i < busy; i++) begin
      noise();
      bus.mem_busy = 1'b1;
      exp_cs_rd = 1'b0;
      @(posedge clk); #1;
    end
    bus.next_addr = na; bus.j_out = j; bus.jmpc = jm; bus.mbr = mb;
    bus.call = c; bus.ret = r; bus.halt = h; bus.mem_busy = 1'b0;
    upd = 1'b0; to_halt = 1'b0; err = 1'b0; do_push = 1'b0; do_pop = 1'b0; nxt = m_mpc;
    if (h) begin
      to_halt = 1'b1;
    end else if (r) begin
      if (m_stk.size() == 0) begin to_halt = 1'b1; err = 1'b1; end
      else begin upd = 1'b1; do_pop = 1'b1; nxt = m_stk[$]; end
    end else if (c) begin
      if (m_stk.size() == DEPTH) begin to_halt = 1'b1; err = 1'b1; end
      else begin upd = 1'b1; do_push = 1'b1; nxt = na; end
    end else begin
      upd = 1'b1;
      nxt = na | (AW'(j) << (AW - 1)) | (jm ? AW'(mb) : AW'(0));
    end
    exp_cs_rd = 1'b0;
    exp_set_f = upd;
    @(posedge clk); #1;
    if (do_push) m_stk.push_back(AW'(m_mpc + 1));
    if (do_pop) void'(m_stk.pop_back());
    m_mpc = nxt;
    if (err) m_err = 1'b1;
    if (to_halt) m_halted = 1'b1;
    if (upd) exp_q.push_back(nxt);
    if (m_halted) set_exp_halt();
    else set_exp_fetch();
  endtask

  task automatic idle_halted(input int n);
    for (int i = 0; i < n; i++) begin
      noise();
      set_exp_halt();
      @(posedge clk); #1;
    end
    check_b("halt_cs_rd", bus.cs_rd, 1'b0);
    check_b("halt_flag", bus.halted, 1'b1);
    check_b("halt_state", seq_state == S_HALT, 1'b1);
  endtask

  initial begin
    int s_setf;
    int s_wait;
    int rv;
    noise();
    set_exp_reset();
    @(posedge clk); #1;
    do_reset();

    // jump bit ORed into the MSB
    run_instr(9'h023, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    check_a("jump_or_j1", bus.mpc, 9'h123);
    s_setf = n_setf;
    run_instr(9'h023, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    check_a("jump_or_j0", bus.mpc, 9'h023);
    check_b("set_f_once", (n_setf - s_setf) == 1, 1'b1);

    // MBR dispatch
    run_instr(9'h100, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 0);
    check_a("dispatch", bus.mpc, 9'h15A);

    // stall for three busy cycles
    s_setf = n_setf;
    s_wait = n_wait;
    run_instr(9'h0F0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3);
    check_a("stall_commit", bus.mpc, 9'h0F0);
    check_b("stall_wait_cycles", (n_wait - s_wait) == 3, 1'b1);
    check_b("stall_set_f_once", (n_setf - s_setf) == 1, 1'b1);

    // call then return
    run_instr(9'h010, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    run_instr(9'h080, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1);
    check_a("call_target", bus.mpc, 9'h080);
    run_instr(9'h3AB, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0);
    check_a("ret_target", bus.mpc, 9'h011);

    // halt arriving with mem_busy is honoured at commit
    run_instr(9'h1FF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2);
    check_a("halt_mpc_hold", bus.mpc, 9'h011);
    check_b("halt_no_err", bus.stk_err, 1'b0);
    idle_halted(3);
    do_reset();

    // call+ret on an empty stack: ret wins and underflows
    run_instr(9'h044, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0);
    check_b("underflow_err", bus.stk_err, 1'b1);
    check_b("underflow_halted", bus.halted, 1'b1);
    check_a("underflow_mpc", bus.mpc, 9'h000);
    idle_halted(2);
    do_reset();

    // five nested calls into a four-deep stack
    for (int i = 1; i <= 4; i++)
      run_instr(AW'(i), 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    run_instr(9'h055, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    check_b("overflow_err", bus.stk_err, 1'b1);
    check_b("overflow_halted", bus.halted, 1'b1);
    check_a("overflow_mpc", bus.mpc, 9'h004);
    idle_halted(4);
    do_reset();

    // reset asserted in the middle of a stall
    run_instr(9'h0AA, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    noise();
    set_exp_fetch();
    @(posedge clk); #1;
    noise();
    bus.mem_busy = 1'b1;
    exp_cs_rd = 1'b0;
    @(posedge clk); #1;
    noise();
    bus.mem_busy = 1'b1;
    do_reset();
    run_instr(9'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0);
    check_b("push_discarded_by_reset", bus.stk_err, 1'b1);
    idle_halted(1);
    do_reset();

    // randomized instruction stream
    for (int k = 0; k < 300; k++) begin
      if (m_halted) begin
        idle_halted(2);
        do_reset();
      end
      rv = $urandom_range(0, 15);
      run_instr(AW'($urandom), 1'($urandom), 1'($urandom), MW'($urandom),
                (rv < 4) || (rv == 13), ((rv >= 4) && (rv < 7)) || (rv == 13),
                rv == 15, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)));
    end
    @(posedge clk); #1;
    check_b("commit_queue_drained", exp_q.size() == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
